// File: rtl/eth_pkg.sv
// Shared types and constants for the GMII transmit framer.
package eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StPayload,
        StAbort,
        StDrain,
        StIfg
    } eth_tx_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// GMII-side TX framer: preamble + SFD + AXI-Stream payload, underrun/error flagging and
// an enforced inter-frame gap. Wire outputs lag the FSM decision by one registered cycle.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN  = 7,
    parameter logic [7:0]  PREAMBLE_BYTE = ETH_PREAMBLE,
    parameter logic [7:0]  SFD_BYTE      = ETH_SFD,
    parameter int unsigned IFG_LEN       = 12
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CntMax = max_u(PREAMBLE_LEN, IFG_LEN);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntPre = CntW'(PREAMBLE_LEN);
    localparam logic [CntW-1:0] CntIfg = CntW'(IFG_LEN);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble_len
        $error("eth_tx_framer: PREAMBLE_LEN must be in 1..15");
    end
    if (IFG_LEN < 1 || IFG_LEN > 255) begin : g_bad_ifg_len
        $error("eth_tx_framer: IFG_LEN must be in 1..255");
    end

    eth_tx_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      txd_q, txd_d;
    logic            tx_en_q, tx_en_d;
    logic            tx_er_q, tx_er_d;
    logic            frame_done_q, frame_done_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            txd_q        <= '0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (s_axis_tvalid) begin
                    state_d = StPreamble;
                    cnt_d   = CntPre;
                end
            end
            StPreamble: begin
                txd_d   = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
                if (cnt_q == CntOne) begin
                    state_d = StSfd;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StSfd: begin
                txd_d   = SFD_BYTE;
                tx_en_d = 1'b1;
                state_d = StPayload;
            end
            StPayload: begin
                tx_en_d = 1'b1;
                if (s_axis_tvalid) begin
                    txd_d   = s_axis_tdata;
                    tx_er_d = s_axis_tuser;
                    if (s_axis_tlast) begin
                        state_d = StIfg;
                        cnt_d   = CntIfg;
                    end
                end else begin
                    // Underrun: one poisoned 00 octet, then drop the rest of the frame.
                    tx_er_d = 1'b1;
                    state_d = StAbort;
                end
            end
            StAbort: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d      = StIfg;
                    cnt_d        = CntIfg;
                    frame_done_d = 1'b1;
                end
            end
            StIfg: begin
                // Drained frames already pulsed on tlast; normal frames pulse on the first idle octet.
                frame_done_d = (cnt_q == CntIfg) && !frame_done_q;
                if (cnt_q == CntOne) begin
                    // Going straight to preamble keeps back-to-back gaps at exactly IFG_LEN.
                    if (s_axis_tvalid) begin
                        state_d = StPreamble;
                        cnt_d   = CntPre;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign s_axis_tready = (state_q == StPayload) || (state_q == StDrain);
    assign busy          = (state_q != StIdle);
    assign gmii_txd      = txd_q;
    assign gmii_tx_en    = tx_en_q;
    assign gmii_tx_er    = tx_er_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomised bench for eth_tx_framer; wire traffic is checked against a frame-level model.
module tb_eth_tx_framer;

    localparam int unsigned PRE   = 7;
    localparam int unsigned IFG   = 12;
    localparam int unsigned PRE_S = 1;
    localparam int unsigned IFG_S = 1;

    logic       clk;
    logic       rst_n;
    int         cyc;

    logic [7:0] tdata;
    logic       tvalid, tready, tlast, tuser;
    logic [7:0] txd;
    logic       tx_en, tx_er, busy, fdone;

    logic [7:0] sm_tdata;
    logic       sm_tvalid, sm_tready, sm_tlast, sm_tuser;
    logic [7:0] sm_txd;
    logic       sm_tx_en, sm_tx_er, sm_busy, sm_fdone;

    int n_checks;
    int n_errors;

    logic [9:0] exp_q[$];
    int         exp_len[$];
    int         exp_fd[$];
    int         exp_gap;
    bit         mon_off;

    eth_tx_framer dut (
        .aclk          (clk),
        .aresetn       (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .s_axis_tuser  (tuser),
        .gmii_txd      (txd),
        .gmii_tx_en    (tx_en),
        .gmii_tx_er    (tx_er),
        .busy          (busy),
        .frame_done    (fdone)
    );

    eth_tx_framer #(
        .PREAMBLE_LEN (PRE_S),
        .IFG_LEN      (IFG_S)
    ) dut_small (
        .aclk          (clk),
        .aresetn       (rst_n),
        .s_axis_tdata  (sm_tdata),
        .s_axis_tvalid (sm_tvalid),
        .s_axis_tready (sm_tready),
        .s_axis_tlast  (sm_tlast),
        .s_axis_tuser  (sm_tuser),
        .gmii_txd      (sm_txd),
        .gmii_tx_en    (sm_tx_en),
        .gmii_tx_er    (sm_tx_er),
        .busy          (sm_busy),
        .frame_done    (sm_fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wire monitor: compares every transmitted octet, frame lengths, gaps and frame_done timing.
    initial begin
        bit         in_frame;
        int         flen;
        int         last_en_cyc;
        int         gap;
        logic [9:0] e;
        in_frame    = 0;
        flen        = 0;
        last_en_cyc = -1000;
        forever begin
            @(negedge clk);
            if (!rst_n || mon_off) begin
                in_frame = 0;
                flen     = 0;
                if (!rst_n) last_en_cyc = -1000;
            end else begin
                if (tx_en) begin
                    if (!in_frame) begin
                        gap = cyc - last_en_cyc - 1;
                        check_eq("ifg_min", 32'(gap >= int'(IFG)), 1);
                        if (exp_gap >= 0) begin
                            check_eq("ifg_exact", gap, exp_gap);
                            exp_gap = -1;
                        end
                        in_frame = 1;
                        flen     = 0;
                    end
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h000;
                    check_eq("wire_octet", {1'b1, tx_er, txd}, e);
                    flen++;
                    last_en_cyc = cyc;
                end else begin
                    if (in_frame) begin
                        in_frame = 0;
                        check_eq("frame_len", flen, (exp_len.size() > 0) ? exp_len.pop_front() : 0);
                    end
                    check_eq("idle_wire", {tx_er, txd}, 0);
                end
                if (exp_fd.size() > 0 && exp_fd[0] == cyc) begin
                    check_eq("frame_done", fdone, 1);
                    void'(exp_fd.pop_front());
                end else if (fdone) begin
                    check_eq("frame_done_spurious", fdone, 0);
                end
            end
        end
    end

    task automatic push_beat(input logic [7:0] b, input bit last, input bit user,
                             output int acc_cyc, output bit ok);
        tvalid  = 1'b1;
        tdata   = b;
        tlast   = last;
        tuser   = user;
        ok      = 0;
        acc_cyc = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (tready) begin
                ok      = 1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("beat_accept", ok, 1);
    endtask

    task automatic send_frame(input int n, input int stall_at, input int user_at,
                              input bit fixed, input bit keep_valid, input int gap);
        logic [7:0] d[$];
        int         acc;
        bit         ok;
        bit         stalled;
        int         shown;
        stalled = (stall_at > 0) && (stall_at < n);
        shown   = stalled ? stall_at : n;
        exp_gap = gap;
        for (int i = 0; i < n; i++) d.push_back(fixed ? 8'(8'hA1 + i) : 8'($urandom));
        for (int i = 0; i < int'(PRE); i++) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, 8'hD5});
        for (int i = 0; i < shown; i++) exp_q.push_back({1'b1, i == user_at, d[i]});
        if (stalled) exp_q.push_back({2'b11, 8'h00});
        exp_len.push_back(int'(PRE) + 1 + shown + (stalled ? 1 : 0));
        for (int i = 0; i < n; i++) begin
            if (stalled && i == stall_at) begin
                tvalid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            push_beat(d[i], i == n - 1, i == user_at, acc, ok);
            // Normal: last octet on the wire next cycle, pulse one after. Drained: pulse next cycle.
            if (i == n - 1 && ok) exp_fd.push_back(stalled ? acc + 1 : acc + 2);
        end
        if (!keep_valid) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            tuser  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = !busy && !tx_en && (exp_fd.size() == 0);
        end
        if (!done) check_eq("idle_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] sm_obs[8];
        logic [8:0] sm_exp;
        bit         seen;
        int         period;
        int         acc;
        bit         ok;
        bit         prev_keep;
        bit         prev_stall;
        int         n;
        int         st;
        int         us;
        bit         kv;

        n_checks  = 0;
        n_errors  = 0;
        exp_gap   = -1;
        mon_off   = 0;
        rst_n     = 1'b0;
        {tdata, tvalid, tlast, tuser}             = '0;
        {sm_tdata, sm_tvalid, sm_tlast, sm_tuser} = '0;
        #1;
        check_eq("reset_outs", {txd, tx_en, tx_er, busy, fdone, tready}, 0);
        check_eq("reset_outs_small", {sm_txd, sm_tx_en, sm_tx_er, sm_busy, sm_fdone}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy_tready", {busy, tready}, 0);

        // Minimal parameters, single-beat frames with tvalid held: 55, D5, 3C, one idle, repeat.
        sm_tvalid = 1'b1;
        sm_tlast  = 1'b1;
        sm_tdata  = 8'h3C;
        seen      = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = sm_tx_en;
        end
        check_eq("small_start", seen, 1);
        sm_obs[0] = {sm_tx_en, sm_txd};
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            sm_obs[k] = {sm_tx_en, sm_txd};
        end
        sm_tvalid = 1'b0;
        period = int'(PRE_S) + 2 + int'(IFG_S);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = k % period;
            if (p < int'(PRE_S))       sm_exp = {1'b1, 8'h55};
            else if (p == int'(PRE_S)) sm_exp = {1'b1, 8'hD5};
            else if (p == int'(PRE_S) + 1) sm_exp = {1'b1, 8'h3C};
            else                       sm_exp = {1'b0, 8'h00};
            check_eq($sformatf("small_wire[%0d]", k), sm_obs[k], sm_exp);
        end
        @(posedge clk);
        #1;

        // Directed frames: plain, back-to-back, underrun, upstream error.
        send_frame(4, -1, -1, 1'b1, 1'b0, -1);
        wait_idle();
        send_frame(5, -1, -1, 1'b0, 1'b1, -1);
        send_frame(3, -1, -1, 1'b0, 1'b0, int'(IFG));
        wait_idle();
        send_frame(6, 2, -1, 1'b1, 1'b0, -1);
        wait_idle();
        send_frame(4, -1, 2, 1'b1, 1'b0, -1);
        wait_idle();
        send_frame(1, -1, -1, 1'b0, 1'b0, -1);
        wait_idle();

        prev_keep  = 0;
        prev_stall = 1;
        for (int f = 0; f < 24; f++) begin
            n  = $urandom_range(1, 16);
            st = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
            us = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            kv = $urandom_range(0, 1);
            send_frame(n, st, us, 1'b0, kv, (prev_keep && !prev_stall) ? int'(IFG) : -1);
            prev_keep  = kv;
            prev_stall = (st > 0);
            if (!kv) repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        wait_idle();

        // Asynchronous reset while the second payload octet is on the wire.
        mon_off = 1;
        push_beat(8'hB1, 1'b0, 1'b0, acc, ok);
        push_beat(8'hB2, 1'b0, 1'b0, acc, ok);
        check_eq("pre_reset_octet", {tx_en, txd}, {1'b1, 8'hB2});
        rst_n  = 1'b0;
        tvalid = 1'b0;
        #1;
        check_eq("async_reset_outs", {txd, tx_en, tx_er, busy, fdone, tready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_reset_idle", {busy, tready, tx_en}, 0);
        end
        mon_off = 0;
        @(posedge clk);
        #1;
        send_frame(3, -1, 0, 1'b0, 1'b0, -1);
        wait_idle();

        check_eq("exp_octets_left", exp_q.size(), 0);
        check_eq("exp_frames_left", exp_len.size(), 0);
        check_eq("exp_done_left", exp_fd.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
